// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// FETCH_PREFETCH_EN selects a 2-entry fetch buffer; otherwise the buffer holds 1 entry.
package if_fetch_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FLUSH = 3'd4
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

`ifdef FETCH_PREFETCH_EN
  localparam int BUF_DEPTH = 2;
`else
  localparam int BUF_DEPTH = 1;
`endif

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_buffer.sv
// In-order fetch buffer (depth 1 or 2) holding {instruction, pc} pairs for decode.
// Depth follows FETCH_PREFETCH_EN through if_fetch_unit_pkg::BUF_DEPTH.
module fetch_buffer
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         clear,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  if (DEPTH == 1) begin : g_single
    logic         valid_q;
    fetch_entry_t slot_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        slot_q  <= '0;
      end else if (clear) begin
        valid_q <= 1'b0;
      end else if (push) begin
        valid_q <= 1'b1;
        slot_q  <= push_entry;
      end else if (pop) begin
        valid_q <= 1'b0;
      end
    end

    assign head  = slot_q;
    assign full  = valid_q;
    assign empty = !valid_q;
  end else begin : g_double
    logic [1:0]   count_q;
    fetch_entry_t slot0_q;
    fetch_entry_t slot1_q;

    // slot0 is always the oldest entry; a pop shifts slot1 down
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count_q <= 2'd0;
        slot0_q <= '0;
        slot1_q <= '0;
      end else if (clear) begin
        count_q <= 2'd0;
      end else begin
        case ({push, pop})
          2'b10: begin
            if (count_q == 2'd0) slot0_q <= push_entry;
            else                 slot1_q <= push_entry;
            count_q <= count_q + 2'd1;
          end
          2'b01: begin
            slot0_q <= slot1_q;
            count_q <= count_q - 2'd1;
          end
          2'b11: begin
            if (count_q == 2'd1) begin
              slot0_q <= push_entry;
            end else begin
              slot0_q <= slot1_q;
              slot1_q <= push_entry;
            end
          end
          default: ;
        endcase
      end
    end

    assign head  = slot0_q;
    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, buffered handoff to decode.
// FETCH_PREFETCH_EN enables a 2-entry buffer so the next fetch overlaps decode stalls.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         buf_push, buf_pop, buf_clear, buf_full, buf_empty;
  logic         load_fills;
  fetch_entry_t buf_head;
  fetch_entry_t load_entry;

  assign buf_clear  = redirect_en;
  assign buf_pop    = !buf_empty && id_ready && !redirect_en;
  assign buf_push   = (state_q == ST_WAIT) && imem_rvalid && !redirect_en && (!buf_full || buf_pop);
  assign load_entry = '{inst: imem_rdata, pc: pc_q};

  // Whether the word loaded this cycle leaves the buffer full, forcing HOLD
`ifdef FETCH_PREFETCH_EN
  assign load_fills = !buf_empty && !buf_pop;
`else
  assign load_fills = 1'b1;
`endif

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (buf_push),
    .push_entry(load_entry),
    .pop       (buf_pop),
    .clear     (buf_clear),
    .head      (buf_head),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  assign imem_req  = (state_q == ST_ISSUE);
  assign imem_addr = imem_req ? pc_q : 32'h0;
  assign id_valid  = !buf_empty;
  assign id_inst   = buf_empty ? NOP_INST : buf_head.inst;
  assign id_pc     = buf_empty ? 32'h0 : buf_head.pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Redirect outranks everything; a request already on the bus must drain through FLUSH
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_en)   pc_d = word_align(redirect_pc);
    else if (buf_push) pc_d = pc_q + 32'd4;

    case (state_q)
      ST_IDLE:  state_d = ST_ISSUE;
      ST_ISSUE: state_d = redirect_en ? ST_FLUSH : ST_WAIT;
      ST_WAIT: begin
        if (redirect_en)      state_d = imem_rvalid ? ST_ISSUE : ST_FLUSH;
        else if (imem_rvalid) state_d = load_fills ? ST_HOLD : ST_ISSUE;
      end
      ST_HOLD: begin
        if (redirect_en || buf_pop) state_d = ST_ISSUE;
      end
      ST_FLUSH: begin
        if (imem_rvalid) state_d = ST_ISSUE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: randomized decode stalls, redirects and memory latency.
// Expected instruction stream is derived from program order, independent of the FSM.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .id_ready   (id_ready),
    .id_valid   (id_valid),
    .id_inst    (id_inst),
    .id_pc      (id_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [31:0] model_pc;
  logic [31:0] req_log[$];
  logic [31:0] del_log[$];
  int          mem_lat = 1;
  bit          mem_hold = 1'b1;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  bit          prev_redirect = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic void sb_refill();
    exp_t e;
    while (exp_q.size() < 8) begin
      e.pc   = model_pc;
      e.inst = mem_word(model_pc);
      exp_q.push_back(e);
      model_pc = model_pc + 32'd4;
    end
  endfunction

  function automatic void sb_restart(input logic [31:0] pc);
    exp_q.delete();
    model_pc = {pc[31:2], 2'b00};
    sb_refill();
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic report_timeout(input string name, input int bound);
    checks++;
    errors++;
    $display("[TB] FAIL %s: event not seen within %0d cycles (got none, required one)", name, bound);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Memory: one pending response, latency fixed or random 1..4 (mem_lat==0)
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mem_hold) begin
        pend = 1'b0;
        continue;
      end
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (imem_req) check_output("one_outstanding", {31'h0, pend}, 32'h0);
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
          pend        = 1'b0;
        end
      end
      if (imem_req) begin
        pend      = 1'b1;
        pend_addr = imem_addr;
        pend_cnt  = (mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat;
        req_log.push_back(imem_addr);
      end
    end
  end

  // Monitor: compares the presented instruction with the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_redirect = 1'b0;
        continue;
      end
      if (prev_redirect) check_output("valid_after_redirect", {31'h0, id_valid}, 32'h0);
      if (!id_valid) begin
        check_output("nop_when_invalid", id_inst, NOP);
      end else if (!redirect_en) begin
        if (exp_q.size() == 0) begin
          report_timeout("scoreboard_empty", 0);
        end else begin
          check_output("id_pc", id_pc, exp_q[0].pc);
          check_output("id_inst", id_inst, exp_q[0].inst);
          if (id_ready) begin
            del_log.push_back(id_pc);
            void'(exp_q.pop_front());
            sb_refill();
          end
        end
      end
      if (imem_req) check_output("addr_aligned", {30'h0, imem_addr[1:0]}, 32'h0);
`ifndef FETCH_PREFETCH_EN
      if (id_valid) check_output("no_req_while_held", {31'h0, imem_req}, 32'h0);
`endif
      prev_redirect = redirect_en;
    end
  end

  task automatic do_reset(input bit stale);
    step();
    mem_hold    = 1'b1;
    rst_n       = 1'b0;
    imem_rvalid = 1'b0;
    redirect_en = 1'b0;
    id_ready    = 1'b0;
    repeat (2) step();
    @(negedge clk);
    check_output("rst_imem_req", {31'h0, imem_req}, 32'h0);
    check_output("rst_imem_addr", imem_addr, 32'h0);
    check_output("rst_id_valid", {31'h0, id_valid}, 32'h0);
    check_output("rst_id_inst", id_inst, NOP);
    check_output("rst_id_pc", id_pc, 32'h0);
    sb_restart(RESET_PC);
    req_log.delete();
    del_log.delete();
    step();
    rst_n = 1'b1;
    if (stale) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    mem_hold = 1'b0;
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    redirect_en = 1'b1;
    redirect_pc = target;
    sb_restart(target);
    step();
    redirect_en = 1'b0;
    redirect_pc = $urandom;
  endtask

  task automatic wait_req(input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      step();
      seen = imem_req;
    end
    if (!seen) report_timeout("wait_req", bound);
  endtask

  task automatic wait_valid(input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      step();
      seen = id_valid;
    end
    if (!seen) report_timeout("wait_valid", bound);
  endtask

  task automatic wait_delivered(input int n, input int bound);
    int base = del_log.size();
    for (int i = 0; i < bound && del_log.size() < base + n; i++) step();
    if (del_log.size() < base + n) report_timeout("wait_delivered", bound);
  endtask

  task automatic wait_reqs(input int base, input int n, input int bound);
    for (int i = 0; i < bound && req_log.size() < base + n; i++) step();
    if (req_log.size() < base + n) report_timeout("wait_reqs", bound);
  endtask

  task automatic apply_stimulus(input int cycles);
    logic [31:0] tgt;
    for (int i = 0; i < cycles; i++) begin
      id_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 39) == 0) begin
        tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : 32'($urandom_range(0, 4095));
        pulse_redirect(tgt);
      end else begin
        step();
      end
    end
    id_ready = 1'b0;
  endtask

  initial begin
    int base;
    int dbase;

    // Reset release, latency 1: fetches at 0 then 4, deliveries 0, 4, 8
    mem_lat = 1;
    do_reset(1'b0);
    id_ready = 1'b1;
    wait_delivered(3, 40);
    check_output("seq_pc0", del_log[0], 32'h0);
    check_output("seq_pc1", del_log[1], 32'h4);
    check_output("seq_pc2", del_log[2], 32'h8);
    check_output("seq_req0", req_log[0], 32'h0);
    check_output("seq_req1", req_log[1], 32'h4);

    // Decode stall for 5 cycles: held entry stays put, no fetch in 1-entry build
    id_ready = 1'b0;
    wait_valid(20);
    base = req_log.size();
    repeat (5) begin
      @(negedge clk);
      check_output("stall_valid", {31'h0, id_valid}, 32'h1);
    end
    if (DEPTH == 1) check_output("stall_no_req", req_log.size() - base, 32'h0);
    step();
    id_ready = 1'b1;

    // Redirect during WAIT, response 2 cycles later must be dropped
    mem_lat = 3;
    wait_req(20);
    step();
    base = req_log.size();
    pulse_redirect(32'h0000_0100);
    wait_reqs(base, 1, 20);
    check_output("flush_next_addr", req_log[base], 32'h0000_0100);
    dbase = del_log.size();
    wait_delivered(1, 30);
    check_output("flush_first_pc", del_log[dbase], 32'h0000_0100);

    // Redirect in the same cycle as the response
    mem_lat = 2;
    wait_req(20);
    step();
    step();
    pulse_redirect(32'h0000_0203);
    @(negedge clk);
    check_output("same_cycle_req", {31'h0, imem_req}, 32'h1);
    check_output("same_cycle_addr", imem_addr, 32'h0000_0200);
    check_output("same_cycle_valid", {31'h0, id_valid}, 32'h0);
    step();

    // Address wrap past the top of memory
    mem_lat = 1;
    base = req_log.size();
    pulse_redirect(32'hFFFF_FFFC);
    wait_reqs(base, 2, 30);
    check_output("wrap_addr0", req_log[base], 32'hFFFF_FFFC);
    check_output("wrap_addr1", req_log[base + 1], 32'h0);

    // Reset during an outstanding request plus a stale response after release
    mem_lat = 4;
    wait_req(20);
    step();
    do_reset(1'b1);
    mem_lat = 1;
    id_ready = 1'b1;
    wait_delivered(2, 40);
    check_output("stale_req0", req_log[0], RESET_PC);
    check_output("stale_pc0", del_log[0], RESET_PC);

    // Randomized stalls, redirects and latency
    mem_lat = 0;
    dbase = del_log.size();
    apply_stimulus(1500);
    check_output("random_progress", {31'h0, (del_log.size() - dbase) > 100}, 32'h1);

    // Stalled decode: exactly DEPTH fetches complete, then retire in order
    mem_lat = 1;
    id_ready = 1'b0;
    repeat (20) step();
    base = req_log.size();
    pulse_redirect(32'h0000_0400);
    repeat (20) step();
    check_output("stall_fetch_count", req_log.size() - base, DEPTH);
    @(negedge clk);
    check_output("stall_hold_valid", {31'h0, id_valid}, 32'h1);
    check_output("stall_hold_pc", id_pc, 32'h0000_0400);
    step();
    dbase = del_log.size();
    id_ready = 1'b1;
    wait_delivered(2, 20);
    check_output("retire_pc0", del_log[dbase], 32'h0000_0400);
    check_output("retire_pc1", del_log[dbase + 1], 32'h0000_0404);

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
